sincos_acq_sched: RTL and testbench

SINCOS_ACQ_SCHED -- requirements
Module: sincos_acq_sched

---
 rtl/sincos_pkg.sv | 38 +++
 rtl/acq_tick_gen.sv | 60 ++++++
 rtl/sincos_acq_sched.sv | 167 ++++++++++++++++
 tb/tb_sincos_acq_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sincos_pkg
// Description : Shared types and constants for the sin/cos acquisition
//               scheduler: FSM state encoding, default timeout, counter
//               widths and a saturating error-counter adder.
// Revision    : 1.0 - initial release
// ============================================================================
package sincos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } acq_state_t;

  localparam int C_PERIOD_W     = 16;
  localparam int C_TIMEOUT_CYC  = 400;
  localparam int C_DATA_W       = 32;
  localparam int C_SAMPLE_CNT_W = 16;
  localparam int C_ERR_CNT_W    = 8;

  // Adds 0..2 error events to the error counter, clamping at all-ones.
  function automatic logic [C_ERR_CNT_W-1:0] err_add_sat(
    input logic [C_ERR_CNT_W-1:0] cnt,
    input logic [1:0]             inc
  );
    logic [C_ERR_CNT_W:0] w_sum;
    w_sum = {1'b0, cnt} + {{(C_ERR_CNT_W-1){1'b0}}, inc};
    if (w_sum[C_ERR_CNT_W]) begin
      return {C_ERR_CNT_W{1'b1}};
    end
    return w_sum[C_ERR_CNT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : acq_tick_gen
// Description : Periodic trigger tick generator. Counts 0..period-1 while
//               running and emits a one-cycle tick on period-1. A changed
//               period is only adopted at the next wrap.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_enable        - run request
//               i_period        - interval in clk cycles (0 = stopped)
//               o_tick          - one-cycle tick (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module acq_tick_gen
  import sincos_pkg::*;
#(
  parameter int PERIOD_W = C_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_active;
  logic                w_run;
  logic [PERIOD_W-1:0] w_period;

  assign w_run    = i_enable && (i_period != '0);
  // On the first running cycle no period has been latched yet, so the live
  // input is used; afterwards the value latched at the last wrap applies.
  assign w_period = r_active ? r_period : i_period;
  assign o_tick   = w_run && (r_cnt == (w_period - PERIOD_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_active <= 1'b0;
    end else if (!w_run) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (o_tick) begin
        r_cnt    <= '0;
        r_period <= i_period;
      end else begin
        r_cnt <= r_cnt + PERIOD_W'(1);
        if (!r_active) begin
          r_period <= i_period;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sincos_acq_sched.sv
`default_nettype none
// ============================================================================
// Module      : sincos_acq_sched
// Description : Periodic sin/cos acquisition scheduler. Issues a key pulse
//               to the sampler on each tick, waits for conv_done (with
//               timeout), holds the captured word until the consumer takes
//               it, and keeps sample and error statistics.
// Ports       : clk, rst_n           - clock, async active-low reset
//               enable, period       - tick control
//               clr_cnt              - clears sample_cnt / err_cnt
//               key                  - trigger to sampler (state TRIG)
//               conv_done, data_in   - sampler result strobe and word
//               data_out, data_valid, data_ready - output handshake
//               busy                 - FSM not idle
//               timeout_err, overrun - one-cycle error pulses
//               sample_cnt, err_cnt  - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module sincos_acq_sched
  import sincos_pkg::*;
#(
  parameter int PERIOD_W    = C_PERIOD_W,
  parameter int TIMEOUT_CYC = C_TIMEOUT_CYC,
  parameter int DATA_W      = C_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [PERIOD_W-1:0]       period,
  input  logic                      clr_cnt,
  output logic                      key,
  input  logic                      conv_done,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      overrun,
  output logic [C_SAMPLE_CNT_W-1:0] sample_cnt,
  output logic [C_ERR_CNT_W-1:0]    err_cnt
);

  localparam int             TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  acq_state_t                r_state;
  acq_state_t                w_state_nxt;
  logic [TMO_W-1:0]          r_tmo_cnt;
  logic [DATA_W-1:0]         r_data_out;
  logic                      r_data_valid;
  logic                      r_timeout_err;
  logic                      r_overrun;
  logic [C_SAMPLE_CNT_W-1:0] r_sample_cnt;
  logic [C_ERR_CNT_W-1:0]    r_err_cnt;

  logic w_tick;
  logic w_capture;
  logic w_timeout;
  logic w_accept;
  logic w_overrun;

  acq_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .i_period (period),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_nxt = ST_TRIG;
        end
      end
      ST_TRIG: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // conv_done takes priority over a coincident timeout.
        if (conv_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (r_tmo_cnt == C_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (r_data_valid && data_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_overrun = w_tick && (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_sample_cnt  <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (r_state == ST_TRIG) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_capture) begin
        r_data_out   <= data_in;
        r_data_valid <= 1'b1;
      end else if (w_accept) begin
        r_data_valid <= 1'b0;
      end

      r_timeout_err <= w_timeout;
      r_overrun     <= w_overrun;

      if (clr_cnt) begin
        r_sample_cnt <= '0;
        r_err_cnt    <= '0;
      end else begin
        if (w_accept) begin
          r_sample_cnt <= r_sample_cnt + C_SAMPLE_CNT_W'(1);
        end
        r_err_cnt <= err_add_sat(r_err_cnt, {1'b0, w_timeout} + {1'b0, w_overrun});
      end
    end
  end

  assign key         = (r_state == ST_TRIG);
  assign busy        = (r_state != ST_IDLE);
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;
  assign sample_cnt  = r_sample_cnt;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sincos_acq_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sincos_acq_sched
// Description : Self-checking bench for sincos_acq_sched. A transaction-level
//               reference model predicts every cycle's outputs into a queue;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sincos_acq_sched;

  localparam int PW  = 16;
  localparam int TMO = 400;
  localparam int DW  = 32;

  localparam int PH_IDLE = 0;
  localparam int PH_TRIG = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_HOLD = 3;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          enable     = 1'b0;
  logic [PW-1:0] period     = '0;
  logic          clr_cnt    = 1'b0;
  logic          conv_done  = 1'b0;
  logic [DW-1:0] data_in    = '0;
  logic          data_ready = 1'b0;
  logic          key;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          timeout_err;
  logic          overrun;
  logic [15:0]   sample_cnt;
  logic [7:0]    err_cnt;

  sincos_acq_sched #(
    .PERIOD_W    (PW),
    .TIMEOUT_CYC (TMO),
    .DATA_W      (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .period      (period),
    .clr_cnt     (clr_cnt),
    .key         (key),
    .conv_done   (conv_done),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          key;
    logic          busy;
    logic          valid;
    logic          to;
    logic          ov;
    logic [DW-1:0] dout;
    logic [15:0]   scnt;
    logic [7:0]    ecnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  int      m_phase    = PH_IDLE;
  bit      m_running  = 1'b0;
  longint  m_cyc      = 0;
  longint  m_next_tick = 0;
  longint  m_deadline = 0;
  logic [DW-1:0] m_data = '0;
  int      m_scnt     = 0;
  int      m_ecnt     = 0;

  task automatic model_step();
    exp_t e;
    bit   tick = 1'b0;
    bit   to   = 1'b0;
    bit   ov   = 1'b0;
    bit   acc  = 1'b0;
    if (!rst_n) begin
      m_phase   = PH_IDLE;
      m_running = 1'b0;
      m_data    = '0;
      m_scnt    = 0;
      m_ecnt    = 0;
    end else begin
      // Ticks: first one period-1 cycles after start, then every latched period.
      if (!(enable && period != 0)) begin
        m_running = 1'b0;
      end else begin
        if (!m_running) begin
          m_running   = 1'b1;
          m_next_tick = m_cyc + longint'(period) - 1;
        end
        if (m_cyc == m_next_tick) begin
          tick        = 1'b1;
          m_next_tick = m_cyc + longint'(period);
        end
      end
      if (tick && m_phase != PH_IDLE) ov = 1'b1;
      case (m_phase)
        PH_IDLE: if (tick) m_phase = PH_TRIG;
        PH_TRIG: begin
          m_phase    = PH_WAIT;
          m_deadline = m_cyc + TMO;
        end
        PH_WAIT: begin
          if (conv_done) begin
            m_data  = data_in;
            m_phase = PH_HOLD;
          end else if (m_cyc == m_deadline) begin
            to      = 1'b1;
            m_phase = PH_IDLE;
          end
        end
        default: begin
          if (data_ready) begin
            acc     = 1'b1;
            m_phase = PH_IDLE;
          end
        end
      endcase
      if (clr_cnt) begin
        m_scnt = 0;
        m_ecnt = 0;
      end else begin
        m_scnt = (m_scnt + int'(acc)) % 65536;
        m_ecnt = m_ecnt + int'(to) + int'(ov);
        if (m_ecnt > 255) m_ecnt = 255;
      end
    end
    e.key   = (m_phase == PH_TRIG);
    e.busy  = (m_phase != PH_IDLE);
    e.valid = (m_phase == PH_HOLD);
    e.to    = to;
    e.ov    = ov;
    e.dout  = m_data;
    e.scnt  = 16'(m_scnt);
    e.ecnt  = 8'(m_ecnt);
    sb_q.push_back(e);
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("key",         32'(key),         32'(e.key));
        check("busy",        32'(busy),        32'(e.busy));
        check("data_valid",  32'(data_valid),  32'(e.valid));
        check("timeout_err", 32'(timeout_err), 32'(e.to));
        check("overrun",     32'(overrun),     32'(e.ov));
        check("data_out",    data_out,         e.dout);
        check("sample_cnt",  32'(sample_cnt),  32'(e.scnt));
        check("err_cnt",     32'(err_cnt),     32'(e.ecnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  int cd_timer = 0;
  int cd_delay = 0;   // 0 = sampler never answers
  bit cd_rand  = 1'b0;
  bit spur     = 1'b0;
  int rdy_mode = 0;   // 0 = ready, 1 = stalled, 2 = random

  task automatic drive_cycle();
    @(negedge clk);
    #1;
    data_in   = $urandom;
    clr_cnt   = 1'b0;
    conv_done = 1'b0;
    if (cd_timer > 0) begin
      cd_timer--;
      if (cd_timer == 0) conv_done = 1'b1;
    end
    if (key) begin
      if (cd_rand) cd_timer = int'($urandom_range(1, 420));
      else         cd_timer = cd_delay;
    end
    if (spur && $urandom_range(0, 15) == 0) conv_done = 1'b1;
    case (rdy_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = 1'b0;
      default: data_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  initial begin
    run(3);
    rst_n = 1'b1;
    run(5);

    // Nominal periodic acquisition.
    period = PW'(200); cd_delay = 50; rdy_mode = 0; enable = 1'b1;
    run(1050);
    enable = 1'b0;
    run(100);

    // Sampler never answers: timeout.
    period = PW'(450); cd_delay = 0; enable = 1'b1;
    run(870);
    enable = 1'b0;
    run(20);

    // Consumer stalls while ticks keep coming: overruns.
    period = PW'(20); cd_delay = 5; rdy_mode = 1; enable = 1'b1;
    run(130);
    rdy_mode = 0;
    run(40);
    enable = 1'b0;
    run(30);

    // conv_done exactly on the timeout cycle, then one cycle too late.
    period = PW'(500); cd_delay = 400; enable = 1'b1;
    run(920);
    enable = 1'b0;
    run(20);
    cd_delay = 401; enable = 1'b1;
    run(920);
    enable = 1'b0;
    run(20);

    // Reset while waiting, then enable dropped while holding.
    period = PW'(30); cd_delay = 0; enable = 1'b1;
    run(40);
    rst_n = 1'b0; cd_timer = 0;
    run(3);
    rst_n = 1'b1; cd_delay = 10; rdy_mode = 1;
    run(50);
    enable = 1'b0;
    run(60);
    rdy_mode = 0;
    run(450);

    // Error counter saturation and clear.
    period = PW'(1); cd_delay = 3; rdy_mode = 1; enable = 1'b1;
    run(310);
    drive_cycle(); clr_cnt = 1'b1;
    run(5);
    enable = 1'b0; rdy_mode = 0;
    run(20);

    // Randomized traffic.
    cd_rand = 1'b1; spur = 1'b1; rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0:       period = '0;
        1:       period = PW'(1);
        2:       period = PW'($urandom_range(2, 6));
        default: period = PW'($urandom_range(10, 600));
      endcase
      enable = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < 150; j++) begin
        drive_cycle();
        if ($urandom_range(0, 99) == 0) clr_cnt = 1'b1;
      end
    end
    enable = 1'b0;
    run(10);

    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
